lsp_expand_gen: RTL and testbench

LSP_EXPAND_GEN -- requirements
Module: lsp_expand_gen

---
 rtl/lsp_expand_gen_if.sv | 28 ++
 rtl/lsp_expand_gen.sv | 166 ++++++++++++++++
 tb/tb_lsp_expand_gen.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/lsp_expand_gen_if.sv
// Scratch-memory bus shared by the LSP expansion engine (master) and the
// word-addressed scratch RAM (slave). Read data arrives one cycle after the
// read address is presented.
interface lsp_expand_gen_if #(
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0] readAddr;
    logic [31:0]       memIn;
    logic [ADDR_W-1:0] writeAddr;
    logic [31:0]       memOut;
    logic              memWriteEn;

    modport master (
        output readAddr,
        input  memIn,
        output writeAddr,
        output memOut,
        output memWriteEn
    );

    modport slave (
        input  readAddr,
        output memIn,
        input  writeAddr,
        input  memOut,
        input  memWriteEn
    );
endinterface

// File: rtl/lsp_expand_gen.sv
// LSP minimum-distance expansion (G.729 Lsp_expand_1_2 style).
// Walks j = lo..hi over an LSP buffer in scratch memory. It pushes
// buf[j-1] and buf[j] apart by tmp = (sub(buf[j-1], buf[j]) + gap) >> 1
// whenever tmp is positive. The updated buf[j] is carried into the next
// iteration in a register, so only buf[lo-1] and each buf[j] are read.
module lsp_expand_gen #(
    parameter int          ORDER     = 10,
    parameter int          ADDR_W    = 12,
    parameter int          IDX_W     = 4,
    // Default word address of the relspwed LSP buffer, buf[0].
    parameter int unsigned BASE_ADDR = 'h100
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [IDX_W-1:0]        loIdx,
    input  logic [IDX_W-1:0]        hiIdx,
    input  logic signed [15:0]      gap,
    lsp_expand_gen_if.master        mem,
    output logic                    done,
    output logic [IDX_W-1:0]        modCount
);

    typedef enum logic [3:0] {
        IDLE, RD_PREV, RD_CUR, LATCH, CALC, WR_PREV, WR_CUR, NEXT, DONE
    } state_t;

    localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(BASE_ADDR);
    localparam logic [IDX_W-1:0]  MAXIDX = IDX_W'(ORDER - 1);

    state_t             state, nextState;
    logic [IDX_W-1:0]   loReg, hiReg, j, jm1;
    logic [IDX_W-1:0]   loEff, hiEff;
    logic signed [15:0] gapReg, prevVal, curVal;
    logic signed [15:0] diffVal, sumVal, tmpVal;
    logic               tmpPos;

    // Saturate a 17-bit signed result into the 16-bit range.
    function automatic logic signed [15:0] sat16(input logic [16:0] v);
        if (v[16] != v[15]) begin
            return v[16] ? 16'sh8000 : 16'sh7FFF;
        end
        return v[15:0];
    endfunction

    function automatic logic signed [15:0] addSat(input logic signed [15:0] a,
                                                  input logic signed [15:0] b);
        return sat16({a[15], a} + {b[15], b});
    endfunction

    function automatic logic signed [15:0] subSat(input logic signed [15:0] a,
                                                  input logic signed [15:0] b);
        return sat16({a[15], a} - {b[15], b});
    endfunction

    // Clamp the requested range to 1..ORDER-1 and compute the expansion step.
    always_comb begin
        loEff   = (loIdx == '0) ? IDX_W'(1) : loIdx;
        hiEff   = (hiIdx > MAXIDX) ? MAXIDX : hiIdx;
        jm1     = j - IDX_W'(1);
        diffVal = subSat(prevVal, curVal);
        sumVal  = addSat(diffVal, gapReg);
        tmpVal  = sumVal >>> 1;
        tmpPos  = !tmpVal[15] && (tmpVal != 16'sd0);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Datapath registers: captured range, carried buffer values and modCount.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loReg    <= '0;
            hiReg    <= '0;
            j        <= '0;
            gapReg   <= '0;
            prevVal  <= '0;
            curVal   <= '0;
            modCount <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        loReg    <= loEff;
                        hiReg    <= hiEff;
                        j        <= loEff;
                        gapReg   <= gap;
                        modCount <= '0;
                    end
                end
                RD_CUR: begin
                    if (j == loReg) begin
                        prevVal <= mem.memIn[15:0];
                    end
                end
                LATCH: curVal <= mem.memIn[15:0];
                CALC: begin
                    if (tmpPos) begin
                        prevVal <= subSat(prevVal, tmpVal);
                        curVal  <= addSat(curVal, tmpVal);
                    end
                end
                WR_CUR: modCount <= modCount + IDX_W'(1);
                NEXT: begin
                    if (j != hiReg) begin
                        j       <= j + IDX_W'(1);
                        prevVal <= curVal;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state logic and state-decoded memory/handshake outputs.
    always_comb begin
        nextState      = state;
        mem.readAddr   = '0;
        mem.writeAddr  = '0;
        mem.memOut     = '0;
        mem.memWriteEn = 1'b0;
        done           = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    nextState = (loEff > hiEff) ? DONE : RD_PREV;
                end
            end
            RD_PREV: begin
                mem.readAddr = BASE + ADDR_W'(jm1);
                nextState    = RD_CUR;
            end
            RD_CUR: begin
                mem.readAddr = BASE + ADDR_W'(j);
                nextState    = LATCH;
            end
            LATCH:   nextState = CALC;
            CALC:    nextState = tmpPos ? WR_PREV : NEXT;
            WR_PREV: begin
                mem.writeAddr  = BASE + ADDR_W'(jm1);
                mem.memOut     = {{16{prevVal[15]}}, prevVal};
                mem.memWriteEn = 1'b1;
                nextState      = WR_CUR;
            end
            WR_CUR: begin
                mem.writeAddr  = BASE + ADDR_W'(j);
                mem.memOut     = {{16{curVal[15]}}, curVal};
                mem.memWriteEn = 1'b1;
                nextState      = NEXT;
            end
            NEXT:    nextState = (j == hiReg) ? DONE : RD_CUR;
            DONE: begin
                done      = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsp_expand_gen.sv
// Directed self-checking bench for lsp_expand_gen with a behavioural
// scratch RAM (one-cycle read latency) attached to the memory interface.
module tb_lsp_expand_gen;

    localparam int ADDR_W = 12;
    localparam int IDX_W  = 4;
    localparam int ORDER  = 10;
    localparam int BASE   = 'h100;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [IDX_W-1:0]  loIdx, hiIdx;
    logic signed [15:0] gap;
    logic              done;
    logic [IDX_W-1:0]  modCount;

    int compared   = 0;
    int mismatched = 0;
    int writeCount = 0;

    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    logic              bdWe = 1'b0;
    logic [ADDR_W-1:0] bdAddr = '0;
    logic [31:0]       bdData = '0;

    lsp_expand_gen_if #(.ADDR_W(ADDR_W)) memBus ();

    lsp_expand_gen #(
        .ORDER(ORDER), .ADDR_W(ADDR_W), .IDX_W(IDX_W), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .loIdx(loIdx), .hiIdx(hiIdx), .gap(gap),
        .mem(memBus), .done(done), .modCount(modCount)
    );

    always #5 clk = ~clk;

    // Scratch RAM: registered read, DUT write port plus a bench backdoor.
    always @(posedge clk) begin
        memBus.memIn <= mem[memBus.readAddr];
        if (memBus.memWriteEn) begin
            mem[memBus.writeAddr] <= memBus.memOut;
            writeCount <= writeCount + 1;
        end else if (bdWe) begin
            mem[bdAddr] <= bdData;
        end
    end

    task automatic setBuf(input int idx, input int value);
        bdWe = 1'b1;
        bdAddr = ADDR_W'(BASE + idx);
        bdData = 32'(value);
        @(posedge clk); #1;
        bdWe = 1'b0;
    endtask

    // Pulse start and wait (bounded) for done; optionally pester the DUT
    // with a held start and changed operands while it is busy.
    task automatic runOp(input int lo, input int hi, input int g, input bit scramble,
                         output int cycles, output bit timedOut);
        loIdx = IDX_W'(lo); hiIdx = IDX_W'(hi); gap = 16'(g); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cycles = 1;
        while (!done && cycles < 100) begin
            if (scramble && cycles < 4) begin
                start = 1'b1; loIdx = 4'd0; hiIdx = 4'd9; gap = -16'sd7;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cycles++;
        end
        start = 1'b0;
        timedOut = !done;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; loIdx = '0; hiIdx = '0; gap = '0;
        repeat (2) @(posedge clk);
        #1;
        compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done got %b want 0", done); end
        compared++; if (modCount !== 4'd0) begin mismatched++; $display("[TB] FAIL reset_modCount got %0d want 0", modCount); end
        compared++; if (memBus.memWriteEn !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_we got %b want 0", memBus.memWriteEn); end
        compared++; if (memBus.readAddr !== 12'd0) begin mismatched++; $display("[TB] FAIL reset_readAddr got %h want 0", memBus.readAddr); end
        compared++; if (memBus.writeAddr !== 12'd0 || memBus.memOut !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_wr got %h/%h want 0/0", memBus.writeAddr, memBus.memOut); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int cyc; bit to; int w0;
        setBuf(4, 1000); setBuf(5, 998);
        w0 = writeCount;
        runOp(5, 5, 5, 1'b1, cyc, to);
        compared++; if (to || cyc > 10) begin mismatched++; $display("[TB] FAIL basic_latency got %0d cycles want <=10", cyc); end
        compared++; if (modCount !== 4'd1) begin mismatched++; $display("[TB] FAIL basic_modCount got %0d want 1", modCount); end
        compared++; if (writeCount - w0 !== 2) begin mismatched++; $display("[TB] FAIL basic_writes got %0d want 2", writeCount - w0); end
        @(posedge clk); #1;
        compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_donePulse got %b want 0", done); end
        compared++; if (mem[BASE+4] !== 32'd997) begin mismatched++; $display("[TB] FAIL basic_buf4 got %h want %h", mem[BASE+4], 32'd997); end
        compared++; if (mem[BASE+5] !== 32'd1001) begin mismatched++; $display("[TB] FAIL basic_buf5 got %h want %h", mem[BASE+5], 32'd1001); end
    endtask

    task automatic test_no_write();
        int cyc; bit to; int w0;
        setBuf(4, 500); setBuf(5, 1000);
        w0 = writeCount;
        runOp(5, 5, 5, 1'b0, cyc, to);
        compared++; if (to) begin mismatched++; $display("[TB] FAIL nowrite_timeout got %0d cycles want done", cyc); end
        compared++; if (modCount !== 4'd0) begin mismatched++; $display("[TB] FAIL nowrite_modCount got %0d want 0", modCount); end
        compared++; if (writeCount !== w0) begin mismatched++; $display("[TB] FAIL nowrite_writes got %0d want 0", writeCount - w0); end
        @(posedge clk); #1;
        compared++; if (mem[BASE+4] !== 32'd500 || mem[BASE+5] !== 32'd1000) begin mismatched++; $display("[TB] FAIL nowrite_buf got %h/%h want 1f4/3e8", mem[BASE+4], mem[BASE+5]); end
    endtask

    task automatic test_saturation();
        int cyc; bit to;
        setBuf(0, 32767); setBuf(1, -32768);
        runOp(1, 1, 10, 1'b0, cyc, to);
        compared++; if (to || modCount !== 4'd1) begin mismatched++; $display("[TB] FAIL sat_modCount got %0d want 1", modCount); end
        @(posedge clk); #1;
        compared++; if (mem[BASE+0] !== 32'd16384) begin mismatched++; $display("[TB] FAIL sat_buf0 got %h want 00004000", mem[BASE+0]); end
        compared++; if (mem[BASE+1] !== 32'hFFFFBFFF) begin mismatched++; $display("[TB] FAIL sat_buf1 got %h want ffffbfff", mem[BASE+1]); end
    endtask

    task automatic test_chain();
        int cyc; bit to; int w0;
        int expChain [10] = '{95, 98, 99, 99, 100, 100, 100, 100, 100, 109};
        for (int i = 0; i < 10; i++) setBuf(i, 100);
        w0 = writeCount;
        runOp(1, 9, 10, 1'b0, cyc, to);
        compared++; if (to || cyc > 66) begin mismatched++; $display("[TB] FAIL chain_latency got %0d cycles want <=66", cyc); end
        compared++; if (modCount !== 4'd9) begin mismatched++; $display("[TB] FAIL chain_modCount got %0d want 9", modCount); end
        compared++; if (writeCount - w0 !== 18) begin mismatched++; $display("[TB] FAIL chain_writes got %0d want 18", writeCount - w0); end
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            compared++;
            if (mem[BASE+i] !== 32'(expChain[i])) begin
                mismatched++;
                $display("[TB] FAIL chain_buf%0d got %h want %h", i, mem[BASE+i], 32'(expChain[i]));
            end
        end
    endtask

    task automatic test_range_bounds();
        int cyc; bit to; int w0;
        w0 = writeCount;
        runOp(7, 3, 5, 1'b0, cyc, to);
        compared++; if (to || cyc > 3) begin mismatched++; $display("[TB] FAIL empty73_latency got %0d cycles want <=3", cyc); end
        compared++; if (modCount !== 4'd0) begin mismatched++; $display("[TB] FAIL empty73_modCount got %0d want 0", modCount); end
        @(posedge clk); #1;
        runOp(0, 0, 5, 1'b0, cyc, to);
        compared++; if (to || cyc > 3) begin mismatched++; $display("[TB] FAIL empty00_latency got %0d cycles want <=3", cyc); end
        compared++; if (writeCount !== w0 || modCount !== 4'd0) begin mismatched++; $display("[TB] FAIL empty00_writes got %0d/%0d want 0/0", writeCount - w0, modCount); end
        @(posedge clk); #1;
        setBuf(8, 200); setBuf(9, 100); setBuf(10, 77);
        runOp(9, 15, 10, 1'b0, cyc, to);
        compared++; if (to || modCount !== 4'd1) begin mismatched++; $display("[TB] FAIL clamp_modCount got %0d want 1", modCount); end
        @(posedge clk); #1;
        compared++; if (mem[BASE+8] !== 32'd145 || mem[BASE+9] !== 32'd155) begin mismatched++; $display("[TB] FAIL clamp_buf got %h/%h want 91/9b", mem[BASE+8], mem[BASE+9]); end
        compared++; if (mem[BASE+10] !== 32'd77) begin mismatched++; $display("[TB] FAIL clamp_buf10 got %h want 4d", mem[BASE+10]); end
    endtask

    task automatic test_start_in_done();
        int cyc; bit to; int w0; bit sawDone;
        setBuf(4, 1000); setBuf(5, 998);
        w0 = writeCount;
        runOp(7, 3, 5, 1'b0, cyc, to);
        loIdx = 4'd5; hiIdx = 4'd5; gap = 16'sd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        sawDone = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) sawDone = 1'b1;
        end
        compared++; if (sawDone || writeCount !== w0) begin mismatched++; $display("[TB] FAIL startInDone got done=%b writes=%0d want 0/0", sawDone, writeCount - w0); end
        compared++; if (modCount !== 4'd0) begin mismatched++; $display("[TB] FAIL startInDone_modCount got %0d want 0", modCount); end
    endtask

    task automatic test_reset_mid_write();
        int cyc; bit to; int n;
        setBuf(4, 1000); setBuf(5, 998);
        loIdx = 4'd5; hiIdx = 4'd5; gap = 16'sd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!memBus.memWriteEn && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        compared++; if (!memBus.memWriteEn) begin mismatched++; $display("[TB] FAIL midReset_noWrite got 0 want write within 20 cycles"); end
        reset = 1'b1;
        #1;
        compared++; if (memBus.memWriteEn !== 1'b0 || done !== 1'b0 || modCount !== 4'd0) begin mismatched++; $display("[TB] FAIL midReset_ctrl got we=%b done=%b mod=%0d want 0", memBus.memWriteEn, done, modCount); end
        compared++; if (memBus.readAddr !== 12'd0 || memBus.writeAddr !== 12'd0 || memBus.memOut !== 32'd0) begin mismatched++; $display("[TB] FAIL midReset_bus got %h/%h/%h want 0", memBus.readAddr, memBus.writeAddr, memBus.memOut); end
        @(posedge clk); #1;
        compared++; if (mem[BASE+4] !== 32'd1000) begin mismatched++; $display("[TB] FAIL midReset_abort got %h want 3e8", mem[BASE+4]); end
        reset = 1'b0;
        runOp(5, 5, 5, 1'b0, cyc, to);
        compared++; if (to || modCount !== 4'd1) begin mismatched++; $display("[TB] FAIL postReset_modCount got %0d want 1", modCount); end
        @(posedge clk); #1;
        compared++; if (mem[BASE+4] !== 32'd997 || mem[BASE+5] !== 32'd1001) begin mismatched++; $display("[TB] FAIL postReset_buf got %h/%h want 3e5/3e9", mem[BASE+4], mem[BASE+5]); end
    endtask

    // Run every scenario in sequence, then report.
    initial begin
        test_reset();
        test_basic();
        test_no_write();
        test_saturation();
        test_chain();
        test_range_bounds();
        test_start_in_done();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
